// File: rtl/text_vram_engine_pkg.sv
// ---------------------------------------------------------------------------
// text_vram_engine_pkg
//
// Shared defines for the TFT text-mode path: where the TFT memory window
// lives, the default text geometry, and the command encoding that the CPU
// side uses to ask the VRAM engine for bulk operations.
//
// Contents:
//   TFT_MEM_BASE / TFT_MEM_SIZE  location and size (bytes) of the TFT window
//   TEXT_COLS_DEFAULT            default characters per text row
//   TEXT_ROWS_DEFAULT            default number of text rows
//   text_cmd_t                   command opcodes (other encodings are illegal)
//   textIdxWidth()               index width needed to address n cells
// ---------------------------------------------------------------------------
package text_vram_engine_pkg;

  localparam logic [31:0] TFT_MEM_BASE = 32'h2000_0000;
  localparam int unsigned TFT_MEM_SIZE = 4096;

  // 80x30 characters (2400 cells) fits comfortably inside the TFT window.
  localparam int unsigned TEXT_COLS_DEFAULT = 80;
  localparam int unsigned TEXT_ROWS_DEFAULT = 30;

  // Opcodes 2'b00 and 2'b11 are deliberately left unassigned; the engine
  // treats them as no-op commands that still complete with a done pulse.
  typedef enum logic [1:0] {
    TEXT_CMD_CLEAR     = 2'b01,
    TEXT_CMD_SCROLL_UP = 2'b10
  } text_cmd_t;

  // Width of a cell index for n cells, never less than one bit so a
  // degenerate 1-cell screen still gets a legal vector.
  function automatic int textIdxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_vram_engine.sv
// ---------------------------------------------------------------------------
// text_vram_engine
//
// Bulk-operation engine for the character (text) VRAM. The CPU keeps direct
// byte write access to the text VRAM; on top of that the engine performs two
// commands without CPU involvement:
//   CLEAR      write the fill character to every cell
//   SCROLL_UP  copy rows 1..ROWS-1 up by one row, then fill the last row
// CPU writes always win the shared write port; the engine simply waits
// (holding its position) whenever the CPU is writing.
//
// Ports:
//   clk            sole clock, all state on rising edge
//   reset          synchronous, active-high
//   cpu_write_en   CPU byte write strobe (already region-qualified)
//   cpu_addr       CPU byte offset within text VRAM
//   cpu_data       CPU character byte
//   cmd_valid      command request
//   cmd_op         command opcode (see text_cmd_t)
//   cmd_fill       fill character for the command
//   cmd_ready      engine idle and able to accept a command
//   busy           command in progress
//   done           one-cycle completion pulse
//   vram_write_en  text VRAM write strobe (CPU or engine)
//   vram_addr      text VRAM write byte offset
//   vram_data      text VRAM write byte
//   vram_rd_en     text VRAM read strobe
//   vram_rd_addr   text VRAM read byte offset
//   vram_rd_data   read data, valid the cycle after vram_rd_en
//
// TEXT_COLS*TEXT_ROWS must not exceed TFT_MEM_SIZE.
// ---------------------------------------------------------------------------
module text_vram_engine
  import text_vram_engine_pkg::*;
#(
  parameter int TEXT_COLS = TEXT_COLS_DEFAULT,
  parameter int TEXT_ROWS = TEXT_ROWS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_write_en,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_fill,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        vram_write_en,
  output logic [31:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_rd_en,
  output logic [31:0] vram_rd_addr,
  input  logic [7:0]  vram_rd_data
);

  localparam int NUM_CELLS  = TEXT_COLS * TEXT_ROWS;
  localparam int IDXW       = textIdxWidth(NUM_CELLS);
  // Number of cells that are copied during a scroll (all rows but the last).
  localparam int SCROLL_LEN = (TEXT_ROWS - 1) * TEXT_COLS;

  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_CELLS - 1);
  localparam logic [IDXW-1:0] SCROLL_LAST = IDXW'(SCROLL_LEN - 1);
  localparam logic [IDXW-1:0] FILL_START  = IDXW'(SCROLL_LEN);
  localparam logic [IDXW-1:0] IDX_ONE     = IDXW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCROLL_RD,
    ST_SCROLL_LAT,
    ST_SCROLL_WR,
    ST_FILL,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      char_q, char_d;
  logic [7:0]      fill_q, fill_d;

  logic            engWe;
  logic [7:0]      engData;

  // Next-state logic for the command sequencer. The opcode itself is not
  // stored: once accepted, the state we jump to already encodes which
  // command is running. Write states only advance when the CPU is not
  // using the write port, so a CPU write simply delays the engine by one
  // cycle with idx and char_q untouched. The read states never touch the
  // write port and therefore keep moving even during CPU writes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    char_d  = char_q;
    fill_d  = fill_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          fill_d = cmd_fill;
          idx_d  = '0;
          if (cmd_op == TEXT_CMD_CLEAR) begin
            state_d = ST_CLEAR;
          end else if (cmd_op == TEXT_CMD_SCROLL_UP) begin
            // A single-row screen has nothing to copy, only the fill.
            if (SCROLL_LEN == 0) begin
              state_d = ST_FILL;
              idx_d   = FILL_START;
            end else begin
              state_d = ST_SCROLL_RD;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_CLEAR: begin
        if (!cpu_write_en) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_SCROLL_RD: begin
        state_d = ST_SCROLL_LAT;
      end

      ST_SCROLL_LAT: begin
        char_d  = vram_rd_data;
        state_d = ST_SCROLL_WR;
      end

      // After the last copied cell idx lands exactly on the first cell of
      // the bottom row, which is where the fill phase starts.
      ST_SCROLL_WR: begin
        if (!cpu_write_en) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = (idx_q == SCROLL_LAST) ? ST_FILL : ST_SCROLL_RD;
        end
      end

      ST_FILL: begin
        if (!cpu_write_en) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State register. Reset wins over everything, so a command in flight is
  // abandoned on the spot and never produces a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      char_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      fill_q  <= fill_d;
    end
  end

  // What the engine would like to write this cycle, before arbitration.
  always_comb begin
    engWe   = 1'b0;
    engData = '0;
    case (state_q)
      ST_CLEAR, ST_FILL: begin
        engWe   = 1'b1;
        engData = fill_q;
      end
      ST_SCROLL_WR: begin
        engWe   = 1'b1;
        engData = char_q;
      end
      default: begin
        engWe   = 1'b0;
        engData = '0;
      end
    endcase
  end

  // Shared write port. The CPU passes straight through combinationally; the
  // engine only gets the port when the CPU is quiet. Engine writes are also
  // masked while reset is high so an aborted command cannot sneak out one
  // last write in the reset cycle. An idle port drives all zeros.
  always_comb begin
    vram_write_en = 1'b0;
    vram_addr     = '0;
    vram_data     = '0;
    if (cpu_write_en) begin
      vram_write_en = 1'b1;
      vram_addr     = cpu_addr;
      vram_data     = cpu_data;
    end else if (engWe && !reset) begin
      vram_write_en = 1'b1;
      vram_addr     = 32'(idx_q);
      vram_data     = engData;
    end
  end

  // Read port and status. All of these are decodes of the state register;
  // they are forced low during reset so the block looks completely quiet
  // until reset is released.
  always_comb begin
    vram_rd_en   = !reset && (state_q == ST_SCROLL_RD);
    vram_rd_addr = vram_rd_en ? (32'(idx_q) + 32'(TEXT_COLS)) : '0;
    cmd_ready    = !reset && (state_q == ST_IDLE);
    busy         = !reset && (state_q != ST_IDLE);
    done         = !reset && (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_text_vram_engine.sv
// ---------------------------------------------------------------------------
// tb_text_vram_engine
//
// Directed bench for text_vram_engine on a 4x3 screen (12 cells). A small
// VRAM model answers reads one cycle after the strobe; every write seen on
// the port is checked against a queue of expected writes (address, data and
// cycle relative to command acceptance) that the stimulus fills in before
// driving each command.
// ---------------------------------------------------------------------------
module tb_text_vram_engine;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_write_en = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_fill = '0;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        vram_write_en;
  logic [31:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_rd_en;
  logic [31:0] vram_rd_addr;
  logic [7:0]  vram_rd_data = '0;

  text_vram_engine #(
    .TEXT_COLS(COLS),
    .TEXT_ROWS(ROWS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_write_en (cpu_write_en),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_fill     (cmd_fill),
    .cmd_ready    (cmd_ready),
    .busy         (busy),
    .done         (done),
    .vram_write_en(vram_write_en),
    .vram_addr    (vram_addr),
    .vram_data    (vram_data),
    .vram_rd_en   (vram_rd_en),
    .vram_rd_addr (vram_rd_addr),
    .vram_rd_data (vram_rd_data)
  );

  // 10-unit clock period.
  initial forever #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         sbQ[$];
  logic [7:0]  mem [0:15];

  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;
  int cycleCnt = 0;
  int acceptCnt = 0;
  int doneCount = 0;
  int lastDoneCnt = 0;
  int readCount = 0;
  int writeCount = 0;
  int unexpectedCount = 0;

  logic        wrPend = 1'b0;
  logic        rdPend = 1'b0;
  logic [31:0] wrAddrS = '0;
  logic [31:0] rdAddrS = '0;
  logic [7:0]  wrDataS = '0;

  // Single comparison point: counts, asserts, and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples the DUT mid-cycle: scoreboards writes, counts reads and done
  // pulses, and hands the sampled port activity to the memory model.
  task automatic negedgeMonitor();
    wr_t e;
    forever begin
      @(negedge clk);
      wrPend  = vram_write_en;
      wrAddrS = vram_addr;
      wrDataS = vram_data;
      rdPend  = vram_rd_en;
      rdAddrS = vram_rd_addr;
      if (vram_rd_en) readCount++;
      if (done) begin
        doneCount++;
        lastDoneCnt = cycleCnt;
      end
      if (vram_write_en) begin
        writeCount++;
        if (sbQ.size() == 0) begin
          unexpectedCount++;
        end else begin
          e = sbQ.pop_front();
          checkOutput($sformatf("wr_c%0d_addr", e.cyc), vram_addr, e.addr);
          checkOutput($sformatf("wr_c%0d_data", e.cyc), 32'(vram_data), 32'(e.data));
          checkOutput($sformatf("wr_c%0d_cycle", e.cyc), 32'(cycleCnt - acceptCnt), 32'(e.cyc));
        end
      end
    end
  endtask

  // VRAM model: commits the write sampled this cycle at the clock edge and
  // presents read data shortly after the edge following the read strobe.
  task automatic posedgeModel();
    forever begin
      @(posedge clk);
      cycleCnt++;
      if (wrPend && (wrAddrS < 32'd16)) mem[wrAddrS[3:0]] = wrDataS;
      if (rdPend) begin
        #1;
        vram_rd_data = (rdAddrS < 32'd16) ? mem[rdAddrS[3:0]] : 8'h00;
      end
    end
  endtask

  // Presents one command for exactly one cycle (cycle 0) and records the
  // cycle index so later cycles can be expressed relative to acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] fill);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_fill  = fill;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acceptCnt = cycleCnt - 1;
  endtask

  // Bounded wait for a new done pulse, then a short idle gap.
  task automatic waitDone(input int base);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (doneCount > base) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pushWrite(input int cyc, input int addr, input logic [7:0] data);
    wr_t e;
    e.cyc  = cyc;
    e.addr = 32'(addr);
    e.data = data;
    sbQ.push_back(e);
  endtask

  int doneBase;
  int readBase;
  int writeBase;

  initial begin
    fork
      posedgeModel();
      negedgeMonitor();
    join_none

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset held for two cycles; everything must be quiet inside reset.
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_flags", 32'({cmd_ready, busy, done, vram_write_en, vram_rd_en}), 32'h0);
    checkOutput("rst_vram_addr", vram_addr, 32'h0);
    checkOutput("rst_vram_data", 32'(vram_data), 32'h0);
    checkOutput("rst_rd_addr", vram_rd_addr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h0);

    // CLEAR with a space: one write per cycle 1..12, done in cycle 13.
    $display("[TB] CLEAR fill 0x20");
    for (int k = 0; k < CELLS; k++) pushWrite(k + 1, k, 8'h20);
    doneBase = doneCount;
    applyStimulus(2'b01, 8'h20);
    waitDone(doneBase);
    checkOutput("clr_done_cycle", 32'(lastDoneCnt - acceptCnt), 32'd13);
    checkOutput("clr_done_count", 32'(doneCount - doneBase), 32'd1);
    checkOutput("clr_sb_left", 32'(sbQ.size()), 32'd0);

    // SCROLL_UP over a memory holding its own addresses.
    $display("[TB] SCROLL_UP fill 0x00");
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    for (int k = 0; k < CELLS - COLS; k++) pushWrite(3 * k + 3, k, 8'(k + COLS));
    for (int k = CELLS - COLS; k < CELLS; k++) pushWrite(3 * (CELLS - COLS) + 1 + (k - (CELLS - COLS)), k, 8'h00);
    doneBase = doneCount;
    readBase = readCount;
    applyStimulus(2'b10, 8'h00);
    waitDone(doneBase);
    checkOutput("scr_done_cycle", 32'(lastDoneCnt - acceptCnt), 32'd29);
    checkOutput("scr_reads", 32'(readCount - readBase), 32'(CELLS - COLS));
    checkOutput("scr_sb_left", 32'(sbQ.size()), 32'd0);
    for (int k = 0; k < CELLS; k++)
      checkOutput($sformatf("scr_mem%0d", k), 32'(mem[k]), (k < CELLS - COLS) ? 32'(k + COLS) : 32'h0);

    // CPU write lands in the cycle CLEAR wants idx 3; engine slips a cycle.
    $display("[TB] CLEAR with CPU write stall");
    for (int k = 0; k < 3; k++) pushWrite(k + 1, k, 8'h20);
    pushWrite(4, 5, 8'h41);
    for (int k = 3; k < CELLS; k++) pushWrite(k + 2, k, 8'h20);
    doneBase = doneCount;
    applyStimulus(2'b01, 8'h20);
    repeat (3) @(posedge clk);
    #1;
    cpu_write_en = 1'b1;
    cpu_addr     = 32'd5;
    cpu_data     = 8'h41;
    @(posedge clk);
    #1;
    cpu_write_en = 1'b0;
    cpu_addr     = '0;
    cpu_data     = '0;
    waitDone(doneBase);
    checkOutput("stall_done_cycle", 32'(lastDoneCnt - acceptCnt), 32'd14);
    checkOutput("stall_sb_left", 32'(sbQ.size()), 32'd0);

    // Reset while SCROLL_UP is about to read for idx 4.
    $display("[TB] reset during SCROLL_UP");
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    for (int k = 0; k < 4; k++) pushWrite(3 * k + 3, k, 8'(k + COLS));
    doneBase = doneCount;
    applyStimulus(2'b10, 8'h00);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_sb_left", 32'(sbQ.size()), 32'd0);
    checkOutput("abort_done_count", 32'(doneCount - doneBase), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("abort_mem4", 32'(mem[4]), 32'h4);

    // Illegal opcode, plus a CLEAR request while the engine is busy.
    $display("[TB] illegal opcode");
    doneBase  = doneCount;
    readBase  = readCount;
    writeBase = writeCount;
    applyStimulus(2'b11, 8'h55);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_fill  = 8'h77;
    @(negedge clk);
    checkOutput("ill_done_c1", 32'(done), 32'h1);
    checkOutput("ill_ready_c1", 32'(cmd_ready), 32'h0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("ill_done_cycle", 32'(lastDoneCnt - acceptCnt), 32'd1);
    checkOutput("ill_done_count", 32'(doneCount - doneBase), 32'd1);
    checkOutput("ill_reads", 32'(readCount - readBase), 32'd0);
    checkOutput("ill_writes", 32'(writeCount - writeBase), 32'd0);
    checkOutput("ill_busy_after", 32'(busy), 32'h0);
    checkOutput("unexpected_writes", 32'(unexpectedCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/text_vram_engine.md
TEXT_VRAM_ENGINE -- requirements
Module: text_vram_engine

Interface
REQ-001 SHALL have parameter TEXT_COLS, default 80, characters per text row.
REQ-002 SHALL have parameter TEXT_ROWS, default 30, text rows; TEXT_COLS*TEXT_ROWS SHALL be <= TFT_MEM_SIZE.
REQ-003 Ports SHALL be:
  clk  in  1  sole clock, all state on posedge
  reset  in  1  synchronous, active-high
  cpu_write_en  in  1  CPU byte write to text VRAM, already region-qualified upstream
  cpu_addr  in  32  byte offset within text VRAM
  cpu_data  in  8  CPU character byte
  cmd_valid  in  1  command request
  cmd_op  in  2  01=CLEAR, 10=SCROLL_UP, 00/11=illegal
  cmd_fill  in  8  fill character
  cmd_ready  out  1  engine can accept a command
  busy  out  1  command in progress
  done  out  1  one-cycle completion pulse
  vram_write_en  out  1  text VRAM write strobe
  vram_addr  out  32  text VRAM byte offset
  vram_data  out  8  text VRAM write byte
  vram_rd_en  out  1  text VRAM read strobe
  vram_rd_addr  out  32  text VRAM read byte offset
  vram_rd_data  in  8  read data, valid the cycle after vram_rd_en

Function
REQ-004 Command accepted on a posedge with cmd_valid && cmd_ready; cmd_op and cmd_fill latched then; cmd_ready = (state==IDLE).
REQ-005 States: IDLE, CLEAR, SCROLL_RD, SCROLL_LAT, SCROLL_WR, FILL, DONE.
REQ-006 CPU priority: when cpu_write_en=1, vram_write_en/addr/data SHALL equal 1/cpu_addr/cpu_data combinationally in that cycle, and the engine write is deferred with the index held.
REQ-007 Otherwise vram_write_en is driven only by engine write states; with no write, vram_write_en=0, vram_addr=0, vram_data=0.
REQ-008 CLEAR: idx 0..N-1 (N=TEXT_COLS*TEXT_ROWS), one write per unstalled cycle, addr=idx, data=fill; after the write at idx N-1 -> DONE.
REQ-009 SCROLL_UP, for idx 0..(TEXT_ROWS-1)*TEXT_COLS-1: SCROLL_RD asserts vram_rd_en, vram_rd_addr=idx+TEXT_COLS; SCROLL_LAT captures vram_rd_data into char_q; SCROLL_WR writes char_q to idx (stall-safe), idx++, back to SCROLL_RD or to FILL after the last idx.
REQ-010 FILL: writes fill to idx (TEXT_ROWS-1)*TEXT_COLS..N-1, one per unstalled cycle, then -> DONE.
REQ-011 CPU stall holds state, idx and char_q; SCROLL_RD and SCROLL_LAT never stall (reads unaffected).
REQ-012 DONE: done=1 for exactly one cycle, cmd_ready=0, -> IDLE; busy=1 in every state except IDLE.
REQ-013 Illegal cmd_op: accepted, no VRAM access, IDLE -> DONE -> IDLE (done on the cycle after acceptance).
REQ-014 cmd_valid outside IDLE is ignored (not queued).
REQ-015 idx width SHALL be $clog2(N); addresses zero-extended to 32 bits; no wrap beyond N-1.
REQ-016 Unstalled latency: CLEAR N+1 cycles accept-to-done; SCROLL_UP 3*(TEXT_ROWS-1)*TEXT_COLS+TEXT_COLS+1.

Reset
REQ-017 On reset: state=IDLE, idx=0, char_q=0; done=0, busy=0, vram_rd_en=0, vram_rd_addr=0; vram_write_en/addr/data follow CPU passthrough only; cmd_ready=1 the cycle after reset deasserts.
REQ-018 Reset mid-command aborts immediately: no further engine writes, no done pulse.

Structure
REQ-019 text_cmd_t enum (CLEAR, SCROLL_UP) and TEXT_COLS/TEXT_ROWS defaults SHALL live in the shared defines package beside TFT_MEM_BASE/TFT_MEM_SIZE; state enum stays local.
REQ-020 No sub-module; CPU/engine priority mux inline.

Verification (bench uses TEXT_COLS=4, TEXT_ROWS=3, N=12)
REQ-021 Reset held 2 cycles -> all outputs 0 during reset, cmd_ready=1 after release.
REQ-022 CLEAR fill=0x20 accepted cycle 0 -> writes addr 0..11 data 0x20 cycles 1..12, done=1 cycle 13 only.
REQ-023 VRAM model byte i=i, SCROLL_UP fill=0x00 -> final addr 0..7 = 0x04..0x0B, addr 8..11 = 0x00, done at cycle 29.
REQ-024 CPU write addr 5 data 0x41 on the cycle CLEAR targets idx 3 -> port shows 5/0x41 that cycle, idx 3 written next cycle, done one cycle later (cycle 14).
REQ-025 Reset asserted during SCROLL_UP at idx 4 -> no engine writes after, no done, cmd_ready=1 after release.
REQ-026 cmd_op=2'b11 -> zero VRAM reads/writes, done=1 exactly one cycle after acceptance; cmd_valid during busy ignored.
